// File: rtl/axis_skid_fifo_if.sv
// Valid/ready stream bundle: payload, end-of-packet marker and handshake.
// The producer side uses the master modport, the consumer side uses slave.
interface axis_skid_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, output last, output valid, input ready);
  modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/axis_skid_fifo.sv
// Circular stream buffer with a registered head beat, synchronous flush,
// an occupancy count and a registered almost-full flag.
module axis_skid_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  axis_skid_fifo_if.slave              s_in,
  axis_skid_fifo_if.master             m_out,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(ALMOST_FULL_THRESH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [DATA_WIDTH:0] r_head;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic                r_almost_full;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_push;
  logic                w_pop;
  logic [AW-1:0]       w_rd_next;
  logic [LW-1:0]       w_level_next;
  logic [DATA_WIDTH:0] w_head_next;

  // Handshake qualification and next-state of the level and head register.
  always_comb begin
    w_in_ready   = !flush && (r_level != LVL_FULL);
    w_out_valid  = !flush && (r_level != LVL_ZERO);
    w_push       = s_in.valid && w_in_ready;
    w_pop        = w_out_valid && m_out.ready;
    w_rd_next    = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + LVL_ONE;
    end else if (w_pop && !w_push) begin
      w_level_next = r_level - LVL_ONE;
    end else begin
      w_level_next = r_level;
    end
    // The incoming beat becomes the head only when nothing older remains.
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_next = {s_in.last, s_in.data};
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // Pointer, level, almost-full and head-beat state.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr      <= PTR_ZERO;
      r_rd_ptr      <= PTR_ZERO;
      r_level       <= LVL_ZERO;
      r_almost_full <= 1'b0;
      r_head        <= {(DATA_WIDTH+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr      <= w_rd_next;
      r_level       <= w_level_next;
      r_almost_full <= (w_level_next >= LVL_AF);
      r_head        <= w_head_next;
    end
  end

  // Beat storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= {s_in.last, s_in.data};
    end
  end

  assign s_in.ready   = w_in_ready;
  assign m_out.valid  = w_out_valid;
  assign m_out.data   = r_head[DATA_WIDTH-1:0];
  assign m_out.last   = r_head[DATA_WIDTH];
  assign level        = r_level;
  assign almost_full  = r_almost_full;
endmodule

// File: tb/tb_axis_skid_fifo.sv
// Directed bench for axis_skid_fifo (8-bit payload, 4 entries): a vector table
// for fill/stall/full/flush/reset, then streaming and random-backpressure packet runs.
module tb_axis_skid_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] level;
  logic       almost_full;

  axis_skid_fifo_if #(.DATA_WIDTH(8)) in_if ();
  axis_skid_fifo_if #(.DATA_WIDTH(8)) out_if ();

  axis_skid_fifo #(.DATA_WIDTH(8), .DEPTH(4), .ALMOST_FULL_THRESH(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .s_in        (in_if),
    .m_out       (out_if),
    .level       (level),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       il;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ol;
    logic [2:0] e_lv;
    logic       e_af;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [7:0] id,
                     input logic il, input logic ordy, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_od, input logic e_ol, input logic [2:0] e_lv,
                     input logic e_af);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_lv = e_lv; v.e_af = e_af;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic [7:0] id,
                       input logic il, input logic ordy);
    reset        = rst;
    flush        = fl;
    in_if.valid  = iv;
    in_if.data   = id;
    in_if.last   = il;
    out_if.ready = ordy;
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] exp_beat;
  int         sent;
  int         got;
  logic       ordy_r;
  logic       iv_r;

  initial begin
    //   rst fl iv  id     il or | ir ov  od     ol lv    af
    add(1'b0,1'b0,1'b1,8'h11,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,3'd0,1'b0);
    add(1'b0,1'b0,1'b1,8'h22,1'b0,1'b0, 1'b1,1'b1,8'h11,1'b0,3'd1,1'b0);
    add(1'b0,1'b0,1'b1,8'h33,1'b1,1'b0, 1'b1,1'b1,8'h11,1'b0,3'd2,1'b0);
    for (int k = 0; k < 5; k++)
      add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,8'h11,1'b0,3'd3,1'b1);
    add(1'b0,1'b0,1'b1,8'h44,1'b0,1'b0, 1'b1,1'b1,8'h11,1'b0,3'd3,1'b1);
    add(1'b0,1'b0,1'b1,8'h55,1'b1,1'b0, 1'b0,1'b1,8'h11,1'b0,3'd4,1'b1);
    add(1'b0,1'b0,1'b1,8'h55,1'b1,1'b1, 1'b0,1'b1,8'h11,1'b0,3'd4,1'b1);
    add(1'b0,1'b0,1'b1,8'h55,1'b1,1'b0, 1'b1,1'b1,8'h22,1'b0,3'd3,1'b1);
    add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,8'h22,1'b0,3'd4,1'b1);
    add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b1,8'h33,1'b1,3'd3,1'b1);
    add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b1,8'h44,1'b0,3'd2,1'b0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b1,8'h55,1'b1,3'd1,1'b0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,3'd0,1'b0);
    add(1'b0,1'b0,1'b1,8'h61,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,3'd0,1'b0);
    add(1'b0,1'b0,1'b1,8'h62,1'b0,1'b0, 1'b1,1'b1,8'h61,1'b0,3'd1,1'b0);
    add(1'b0,1'b0,1'b1,8'h63,1'b0,1'b0, 1'b1,1'b1,8'h61,1'b0,3'd2,1'b0);
    add(1'b0,1'b1,1'b1,8'h64,1'b0,1'b1, 1'b0,1'b0,8'h00,1'b0,3'd3,1'b1);
    add(1'b0,1'b0,1'b1,8'h77,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,3'd0,1'b0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,8'h77,1'b0,3'd1,1'b0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b1,8'h77,1'b0,3'd1,1'b0);
    add(1'b0,1'b0,1'b1,8'h81,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,3'd0,1'b0);
    add(1'b0,1'b0,1'b1,8'h82,1'b0,1'b0, 1'b1,1'b1,8'h81,1'b0,3'd1,1'b0);
    add(1'b1,1'b1,1'b1,8'h83,1'b0,1'b1, 1'b0,1'b0,8'h00,1'b0,3'd2,1'b0);
    add(1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,3'd0,1'b0);

    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].il, vecs[i].ordy);
      #1;
      check("in_ready", i, 32'(in_if.ready), 32'(vecs[i].e_ir));
      check("out_valid", i, 32'(out_if.valid), 32'(vecs[i].e_ov));
      check("level", i, 32'(level), 32'(vecs[i].e_lv));
      check("almost_full", i, 32'(almost_full), 32'(vecs[i].e_af));
      if (vecs[i].e_ov) begin
        check("out_data", i, 32'(out_if.data), 32'(vecs[i].e_od));
        check("out_last", i, 32'(out_if.last), 32'(vecs[i].e_ol));
      end
      @(negedge clk);
    end

    // 64 back-to-back beats with a free-running sink: one cycle of latency, then level 1.
    for (int c = 0; c <= 64; c++) begin
      drive(1'b0, 1'b0, (c < 64) ? 1'b1 : 1'b0, 8'(c), 1'b0, 1'b1);
      #1;
      if (c == 0) begin
        check("stream_ov0", c, 32'(out_if.valid), 32'd0);
        check("stream_lv0", c, 32'(level), 32'd0);
      end else begin
        check("stream_ov", c, 32'(out_if.valid), 32'd1);
        check("stream_od", c, 32'(out_if.data), 32'(c - 1));
        check("stream_lv", c, 32'(level), 32'd1);
      end
      if (c < 64) check("stream_ir", c, 32'(in_if.ready), 32'd1);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("stream_drained_lv", 0, 32'(level), 32'd0);
    check("stream_drained_ov", 0, 32'(out_if.valid), 32'd0);
    @(negedge clk);

    // Three-beat packet under seeded random backpressure, tracked by a scoreboard.
    void'($urandom(32'd7));
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60; c++) begin
      iv_r   = (sent < 3) ? 1'b1 : 1'b0;
      ordy_r = 1'($urandom_range(0, 1));
      drive(1'b0, 1'b0, iv_r, 8'(8'hA0 + sent), (sent == 2) ? 1'b1 : 1'b0, ordy_r);
      #1;
      if (out_if.valid && ordy_r) begin
        if (exp_q.size() == 0) begin
          check("pkt_extra_beat", c, 32'(out_if.data), 32'hFFFF_FFFF);
        end else begin
          exp_beat = exp_q.pop_front();
          check("pkt_data", c, 32'(out_if.data), 32'(exp_beat[7:0]));
          check("pkt_last", c, 32'(out_if.last), 32'(exp_beat[8]));
          got++;
        end
      end
      if (iv_r && in_if.ready) begin
        exp_q.push_back({(sent == 2) ? 1'b1 : 1'b0, 8'(8'hA0 + sent)});
        sent++;
      end
      @(negedge clk);
    end
    check("pkt_sent", 0, 32'(sent), 32'd3);
    check("pkt_received", 0, 32'(got), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("pkt_end_ov", 0, 32'(out_if.valid), 32'd0);
    check("pkt_end_lv", 0, 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
